// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-set constants for the CPU writeback path
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int NUM_REQ  = 2;
  localparam logic [ADDR_W-1:0] R0_ADDR = '0;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: request vector + pointer -> one-hot grant
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Walk from ptr upwards, wrapping; first asserted request wins.
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter and one-cycle write stage for the register-set write port
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = regfile_pkg::NUM_REQ,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg_addr,
  output logic [DATA_W-1:0]         write_data,
  output logic                      pend_valid,
  output logic [ADDR_W-1:0]         pend_addr,
  output logic [15:0]               grant_cnt
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] req_masked;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               drop_r0;

  // Nothing is granted while flushing or while reset is held.
  assign req_masked = req_valid & {NUM_REQ{~flush & rst_n}};

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req   (req_masked),
    .ptr   (ptr),
    .grant (req_ready),
    .idx   (gidx),
    .found (xfer)
  );

  assign sel_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(gidx)*DATA_W +: DATA_W];
  assign drop_r0  = PROTECT_R0 && (sel_addr == ADDR_W'(R0_ADDR));
  assign next_ptr = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write      <= 1'b0;
      write_reg_addr <= '0;
      write_data     <= '0;
      ptr            <= '0;
      grant_cnt      <= '0;
    end else begin
      reg_write <= xfer && !drop_r0;
      if (xfer) begin
        ptr       <= next_ptr;
        grant_cnt <= grant_cnt + 16'd1;
        // A discarded R0 write leaves the visible stage contents untouched.
        if (!drop_r0) begin
          write_reg_addr <= sel_addr;
          write_data     <= sel_data;
        end
      end
    end
  end

  assign pend_valid = reg_write;
  assign pend_addr  = write_reg_addr;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [3:0]  a0, a1;
  logic [7:0]  d0, d1;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        reg_write;
  logic [3:0]  write_reg_addr;
  logic [7:0]  write_data;
  logic        pend_valid;
  logic [3:0]  pend_addr;
  logic [15:0] grant_cnt;

  logic [7:0]  regs [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  assign req_addr = {a1, a0};
  assign req_data = {d1, d0};

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .reg_write      (reg_write),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .pend_valid     (pend_valid),
    .pend_addr      (pend_addr),
    .grant_cnt      (grant_cnt)
  );

  // Register set model driven only by the arbiter's write port.
  always @(posedge clk) begin
    if (reg_write) regs[write_reg_addr] <= write_data;
  end

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 2'b11;
    a0 = 4'd2; d0 = 8'h11; a1 = 4'd9; d1 = 8'h22;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", req_ready); end
    n_cmp++; if (grant_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", grant_cnt); end
    n_cmp++; if ({pend_valid, pend_addr, write_data} !== 13'd0) begin n_bad++; $display("FAIL reset_stage got %b/%h/%h want 0", pend_valid, pend_addr, write_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL release_ready got %b want 01", req_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if ({reg_write, write_reg_addr, write_data} !== {1'b1, 4'd2, 8'h11}) begin n_bad++; $display("FAIL release_write got %b/%h/%h want 1/2/11", reg_write, write_reg_addr, write_data); end
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL release_cnt got %0d want %0d", grant_cnt, exp_cnt); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    req_valid = 2'b10; a1 = 4'd5; d1 = 8'hA7;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL single_ready got %b want 10", req_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if ({reg_write, write_reg_addr, write_data} !== {1'b1, 4'd5, 8'hA7}) begin n_bad++; $display("FAIL single_write got %b/%h/%h want 1/5/a7", reg_write, write_reg_addr, write_data); end
    n_cmp++; if ({pend_valid, pend_addr} !== {1'b1, 4'd5}) begin n_bad++; $display("FAIL single_pend got %b/%h want 1/5", pend_valid, pend_addr); end
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (regs[5] !== 8'hA7) begin n_bad++; $display("FAIL single_readback got %h want a7", regs[5]); end
    n_cmp++; if ({reg_write, write_reg_addr, write_data} !== {1'b0, 4'd5, 8'hA7}) begin n_bad++; $display("FAIL single_hold got %b/%h/%h want 0/5/a7", reg_write, write_reg_addr, write_data); end
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL single_cnt got %0d want %0d", grant_cnt, exp_cnt); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    @(negedge clk);
    req_valid = 2'b11; a0 = 4'd3; d0 = 8'h30; a1 = 4'd7; d1 = 8'h70;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (req_ready !== exp_g[c]) begin n_bad++; $display("FAIL contend_ready[%0d] got %b want %b", c, req_ready, exp_g[c]); end
      @(posedge clk); #1;
      exp_cnt = exp_cnt + 16'd1;
      n_cmp++;
      if (exp_g[c][0] ? ({reg_write, write_reg_addr, write_data} !== {1'b1, 4'd3, 8'h30})
                      : ({reg_write, write_reg_addr, write_data} !== {1'b1, 4'd7, 8'h70})) begin
        n_bad++; $display("FAIL contend_write[%0d] got %b/%h/%h", c, reg_write, write_reg_addr, write_data);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL contend_cnt got %0d want %0d", grant_cnt, exp_cnt); end
  endtask

  task automatic test_r0_protect();
    req_valid = 2'b01; a0 = 4'd0; d0 = 8'hFF;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL r0_ready got %b want 01", req_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL r0_reg_write got %b want 0", reg_write); end
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL r0_cnt got %0d want %0d", grant_cnt, exp_cnt); end
    @(negedge clk);
    req_valid = 2'b11; a0 = 4'd4; a1 = 4'd6;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL r0_ptr_adv got %b want 10", req_ready); end
    req_valid = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (regs[0] !== 8'h00) begin n_bad++; $display("FAIL r0_reg0 got %h want 00", regs[0]); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    req_valid = 2'b01; a0 = 4'd8; d0 = 8'h88;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL flush_n_ready got %b want 01", req_ready); end
    @(negedge clk);
    flush = 1'b1; req_valid = 2'b10; a1 = 4'hC; d1 = 8'hCC;
    #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL flush_ready got %b want 00", req_ready); end
    n_cmp++; if ({reg_write, write_reg_addr} !== {1'b1, 4'd8}) begin n_bad++; $display("FAIL flush_staged got %b/%h want 1/8", reg_write, write_reg_addr); end
    @(negedge clk);
    flush = 1'b0; req_valid = 2'b11;
    #1;
    n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL flush_cleared got %b want 0", reg_write); end
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL flush_cnt got %0d want %0d", grant_cnt, exp_cnt); end
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL flush_ptr_hold got %b want 10", req_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if ({reg_write, write_reg_addr, write_data} !== {1'b1, 4'hC, 8'hCC}) begin n_bad++; $display("FAIL flush_after got %b/%h/%h want 1/c/cc", reg_write, write_reg_addr, write_data); end
    n_cmp++; if (regs[8] !== 8'h88) begin n_bad++; $display("FAIL flush_reg8 got %h want 88", regs[8]); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 2'b01; a0 = 4'hB; d0 = 8'hBB;
    @(posedge clk); #1;
    n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL areset_staged got %b want 1", reg_write); end
    req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_cmp++; if ({reg_write, pend_valid} !== 2'b00) begin n_bad++; $display("FAIL areset_drop got %b%b want 00", reg_write, pend_valid); end
    n_cmp++; if (grant_cnt !== 16'd0) begin n_bad++; $display("FAIL areset_cnt got %0d want 0", grant_cnt); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL areset_ptr got %b want 01", req_ready); end
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++; if (grant_cnt !== exp_cnt) begin n_bad++; $display("FAIL areset_cnt_after got %0d want %0d", grant_cnt, exp_cnt); end
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  initial begin
    for (int r = 0; r < 16; r++) regs[r] = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_r0_protect();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
